usbf_wb_master_q: RTL

Queued, parametrised Wishbone classic master for the USB function core. Controller-side requests (read or write, with byte lanes) are accepted into a command FIFO of configurable depth and issued one at a time as Wishbone classic cycles. Each cycle completes on ack, error, or a programmable timeout, and returns a one-cycle response (read data plus status). The block replaces the single-shot wr_en/rd_en master between the USB controller and the Wishbone fabric.

---
 rtl/usbf_wb_pkg.sv | 23 ++
 rtl/usbf_wb_master_q_if.sv | 25 ++
 rtl/usbf_wb_cmd_fifo.sv | 69 ++++++
 rtl/usbf_wb_master_q.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/usbf_wb_pkg.sv
// Shared types and constants for the queued Wishbone master of the USB function core.
package usbf_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } wb_state_t;

   // Response status word: one bit per termination cause, all-zero for a clean ack.
   typedef logic [1:0] rsp_st_t;
   localparam rsp_st_t RSP_OK      = 2'b00;
   localparam rsp_st_t RSP_ERR     = 2'b01;
   localparam rsp_st_t RSP_TMO     = 2'b10;
   localparam int      RSP_ERR_BIT = 0;
   localparam int      RSP_TMO_BIT = 1;

   // Packed command record {we, sel, dat, adr}.
   function automatic int cmd_width(input int aw, input int dw);
      return 1 + dw / 8 + dw + aw;
   endfunction

endpackage

// File: rtl/usbf_wb_master_q_if.sv
// Wishbone classic bus between the queued master and the fabric.
interface usbf_wb_master_q_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 18
);
   logic                  cyc_o;
   logic                  stb_o;
   logic                  we_o;
   logic [AWIDTH-1:0]     adr_o;
   logic [DWIDTH-1:0]     dat_o;
   logic [DWIDTH/8-1:0]   sel_o;
   logic [DWIDTH-1:0]     dat_i;
   logic                  ack_i;
   logic                  err_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      input  dat_i, ack_i, err_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      output dat_i, ack_i, err_i
   );
endinterface

// File: rtl/usbf_wb_cmd_fifo.sv
// Command FIFO: head entry always visible on head, registered full/empty, flush empties it.
module usbf_wb_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int CMD_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush,
   input  logic             push,
   input  logic [CMD_W-1:0] push_data,
   input  logic             pop,
   output logic [CMD_W-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic [PW:0]      count_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + CNT_ONE;
      else if (pop_ok && !push_ok)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/usbf_wb_master_q.sv
// Queued Wishbone classic master: buffers controller requests and issues them one cycle at a time.
//
// state | meaning
// IDLE  | waiting for a queued command; pops the head when one is present
// BUS   | Wishbone cycle in flight, timeout counting down
// DONE  | one-cycle response pulse, then back to IDLE
module usbf_wb_master_q
   import usbf_wb_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 18,
   parameter int DEPTH  = 4,
   parameter int TMO_W  = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [AWIDTH-1:0]   req_adr,
   input  logic [DWIDTH-1:0]   req_dat,
   input  logic [DWIDTH/8-1:0] req_sel,
   output logic                rsp_valid,
   output logic [DWIDTH-1:0]   rsp_dat,
   output logic                rsp_err,
   output logic                rsp_tmo,
   input  logic                abort,
   output logic                busy,
   usbf_wb_master_q_if.master  wb
);
   localparam int SW    = DWIDTH / 8;
   localparam int CMD_W = cmd_width(AWIDTH, DWIDTH);

   // Loaded one below all-ones so the terminal count lands on the (2**TMO_W-1)th BUS cycle.
   localparam logic [TMO_W-1:0] TMO_LOAD = {{(TMO_W - 1){1'b1}}, 1'b0};
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   typedef struct packed {
      logic              we;
      logic [SW-1:0]     sel;
      logic [DWIDTH-1:0] dat;
      logic [AWIDTH-1:0] adr;
   } cmd_t;

   wb_state_t        state;
   logic [TMO_W-1:0] tmo_cnt;
   rsp_st_t          rsp_st;
   cmd_t             push_cmd;
   cmd_t             head_cmd;
   logic [CMD_W-1:0] head_raw;
   logic             full;
   logic             empty;
   logic             pop;

   assign push_cmd  = {req_we, req_sel, req_dat, req_adr};
   assign head_cmd  = cmd_t'(head_raw);
   assign pop       = (state == ST_IDLE) && !empty && !abort;
   assign req_ready = !full;
   assign busy      = !empty || (state != ST_IDLE);
   assign rsp_err   = rsp_st[RSP_ERR_BIT];
   assign rsp_tmo   = rsp_st[RSP_TMO_BIT];

   usbf_wb_cmd_fifo #(
      .DEPTH (DEPTH),
      .CMD_W (CMD_W)
   ) u_cmd_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush     (abort),
      .push      (req_valid),
      .push_data (push_cmd),
      .pop       (pop),
      .head      (head_raw),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         rsp_st    <= RSP_OK;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         wb.cyc_o  <= 1'b0;
         wb.stb_o  <= 1'b0;
         wb.we_o   <= 1'b0;
         wb.adr_o  <= '0;
         wb.dat_o  <= '0;
         wb.sel_o  <= '0;
      end else if (abort) begin
         state     <= ST_IDLE;
         rsp_st    <= RSP_OK;
         rsp_valid <= 1'b0;
         wb.cyc_o  <= 1'b0;
         wb.stb_o  <= 1'b0;
         wb.we_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  wb.adr_o <= head_cmd.adr;
                  wb.dat_o <= head_cmd.dat;
                  wb.sel_o <= head_cmd.sel;
                  wb.we_o  <= head_cmd.we;
                  wb.cyc_o <= 1'b1;
                  wb.stb_o <= 1'b1;
                  tmo_cnt  <= TMO_LOAD;
                  state    <= ST_BUS;
               end
            end
            ST_BUS: begin
               if (wb.err_i || wb.ack_i || (tmo_cnt == '0)) begin
                  wb.cyc_o  <= 1'b0;
                  wb.stb_o  <= 1'b0;
                  wb.we_o   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= ST_DONE;
                  if (wb.err_i)
                     rsp_st <= RSP_ERR;
                  else if (wb.ack_i) begin
                     rsp_st <= RSP_OK;
                     if (!wb.we_o)
                        rsp_dat <= wb.dat_i;
                  end else
                     rsp_st <= RSP_TMO;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_ONE;
               end
            end
            ST_DONE: begin
               rsp_valid <= 1'b0;
               rsp_st    <= RSP_OK;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
